// File: rtl/counter_nonoverlap_clkgen.sv
// counter_nonoverlap_clkgen: counter-based MOD/MODN/MODL modulator clock generator on USER_CLOCK
// Ports:
//   user_clock_i    sole clock, all logic on its rising edge
//   reset_i         synchronous active-high reset
//   freq_sel_i      asynchronous frequency select, 0-5 pick HALF_n, 6/7 idle
//   phase_sel_i     asynchronous MODL phase select, PHASE_STEP cycles per LSB
//   clk_out_mod_o   phase A
//   clk_out_modn_o  phase B, non-overlapping complement of A
//   clk_out_modl_o  phase-shifted 50 % clock
//   period_sync_o   one-cycle pulse at each period start
module counter_nonoverlap_clkgen #(
    parameter int DEADTIME   = 4,
    parameter int PHASE_STEP = 4,
    parameter int HALF_0     = 500,
    parameter int HALF_1     = 250,
    parameter int HALF_2     = 100,
    parameter int HALF_3     = 50,
    parameter int HALF_4     = 25,
    parameter int HALF_5     = 13
) (
    input  logic       user_clock_i,
    input  logic       reset_i,
    input  logic [2:0] freq_sel_i,
    input  logic [4:0] phase_sel_i,
    output logic       clk_out_mod_o,
    output logic       clk_out_modn_o,
    output logic       clk_out_modl_o,
    output logic       period_sync_o
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [9:0] DT = 10'(DEADTIME);

    state_t      state_q;
    logic [2:0]  fs_meta_q, fs_q;
    logic [4:0]  ps_meta_q, ps_q;
    logic [9:0]  cnt_q, h_q, dt_q, ph_q;
    logic        mod_q, modn_q, modl_q, sync_q;
    logic [9:0]  h_d, dt_d, ph_d;
    logic [10:0] two_h_d, two_h, sum, sum_mod;
    logic [15:0] ph_raw;
    logic        valid, wrap, mod_d, modn_d, modl_d, sync_d;

    always_comb begin
        h_d     = fs_q == 3'd0 ? 10'(HALF_0) :
                  fs_q == 3'd1 ? 10'(HALF_1) :
                  fs_q == 3'd2 ? 10'(HALF_2) :
                  fs_q == 3'd3 ? 10'(HALF_3) :
                  fs_q == 3'd4 ? 10'(HALF_4) : 10'(HALF_5);
        two_h_d = {h_d, 1'b0};
        dt_d    = DT >= h_d ? h_d - 10'd1 : DT;
        // full-width product so large PHASE_SEL values clamp instead of wrapping
        ph_raw  = 16'(ps_q) * 16'(PHASE_STEP);
        ph_d    = ph_raw >= 16'(two_h_d) ? 10'(two_h_d - 11'd1) : ph_raw[9:0];
        valid   = fs_q <= 3'd5;
        two_h   = {h_q, 1'b0};
        wrap    = {1'b0, cnt_q} == two_h - 11'd1;
        // cnt + 2H - ph stays below 2048; one conditional subtract folds it into 0..2H-1
        sum     = {1'b0, cnt_q} + two_h - {1'b0, ph_q};
        sum_mod = sum >= two_h ? sum - two_h : sum;
        mod_d   = cnt_q >= dt_q && cnt_q < h_q;
        modn_d  = {1'b0, cnt_q} >= {1'b0, h_q} + {1'b0, dt_q};
        modl_d  = sum_mod < {1'b0, h_q};
        sync_d  = cnt_q == 10'd0;
    end

    always_ff @(posedge user_clock_i) begin
        if (reset_i) begin
            // idle code, so a cleared synchroniser cannot start a period by itself
            fs_meta_q <= 3'd7;
            fs_q      <= 3'd7;
            ps_meta_q <= 5'd0;
            ps_q      <= 5'd0;
            state_q   <= IDLE;
            cnt_q     <= 10'd0;
            h_q       <= 10'd0;
            dt_q      <= 10'd0;
            ph_q      <= 10'd0;
            mod_q     <= 1'b0;
            modn_q    <= 1'b0;
            modl_q    <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            fs_meta_q <= freq_sel_i;
            fs_q      <= fs_meta_q;
            ps_meta_q <= phase_sel_i;
            ps_q      <= ps_meta_q;
            mod_q     <= state_q == RUN && mod_d;
            modn_q    <= state_q == RUN && modn_d;
            modl_q    <= state_q == RUN && modl_d;
            sync_q    <= state_q == RUN && sync_d;
            if (state_q == IDLE || wrap) begin
                // settings only change here, at a period boundary
                cnt_q <= 10'd0;
                if (valid) begin
                    state_q <= RUN;
                    h_q     <= h_d;
                    dt_q    <= dt_d;
                    ph_q    <= ph_d;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                cnt_q <= cnt_q + 10'd1;
            end
        end
    end

    assign clk_out_mod_o  = mod_q;
    assign clk_out_modn_o = modn_q;
    assign clk_out_modl_o = modl_q;
    assign period_sync_o  = sync_q;
endmodule
